// File: rtl/game_text_buffer_if.sv
// Bundle of the text buffer's read, write/command and status signals.
// The game logic is the master and the buffer is the slave.
interface game_text_buffer_if;
  logic [7:0] char_xy;
  logic [6:0] char_code;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_op;
  logic [6:0] wr_char;
  logic       clear_req;
  logic       busy;
  logic [7:0] cursor_xy;

  modport master (
    output char_xy,
    input  char_code,
    output wr_valid,
    input  wr_ready,
    output wr_op,
    output wr_char,
    output clear_req,
    input  busy,
    input  cursor_xy
  );

  modport slave (
    input  char_xy,
    output char_code,
    input  wr_valid,
    output wr_ready,
    input  wr_op,
    input  wr_char,
    input  clear_req,
    output busy,
    output cursor_xy
  );
endinterface

// File: rtl/game_text_buffer.sv
// Writable 4x16 character buffer with cursor commands and a one-cell-per-cycle clear sweep.
// The registered read port matches the fixed text ROM address format.
module game_text_buffer #(
  parameter logic [6:0]  SPACE_CODE = 7'h20,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 16
) (
  input logic               clk,
  input logic               rst,
  game_text_buffer_if.slave bus
);

  localparam int unsigned Cells = ROWS * COLS;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam logic [1:0] OpPut       = 2'b00;
  localparam logic [1:0] OpNewline   = 2'b01;
  localparam logic [1:0] OpBackspace = 2'b10;
  localparam logic [1:0] OpHome      = 2'b11;

  state_e     state_q, state_d;
  logic [5:0] cur_q, cur_d;
  logic [5:0] sweep_q, sweep_d;
  logic [6:0] cell_q [Cells];
  logic [6:0] char_code_q;

  logic       busy;
  logic       accept;
  logic       we;
  logic [5:0] waddr;
  logic [6:0] wdata;

  assign busy   = (state_q == StClear);
  assign accept = bus.wr_valid && !busy;

  assign bus.busy      = busy;
  assign bus.wr_ready  = !busy;
  assign bus.cursor_xy = {2'b00, cur_q};
  assign bus.char_code = char_code_q;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    sweep_d = sweep_q;
    we      = 1'b0;
    waddr   = cur_q;
    wdata   = SPACE_CODE;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (bus.wr_op)
            OpPut: begin
              we    = 1'b1;
              waddr = cur_q;
              wdata = bus.wr_char;
              cur_d = cur_q + 6'd1;
            end
            OpNewline: begin
              cur_d = {cur_q[5:4] + 2'd1, 4'h0};
            end
            OpBackspace: begin
              if (cur_q != 6'd0) begin
                we    = 1'b1;
                waddr = cur_q - 6'd1;
                wdata = SPACE_CODE;
                cur_d = cur_q - 6'd1;
              end
            end
            OpHome: begin
              cur_d = 6'd0;
            end
            default: ;
          endcase
        end
        // A concurrent write still lands; the sweep later overwrites it and the cursor resets.
        if (bus.clear_req) begin
          state_d = StClear;
          sweep_d = 6'd0;
          cur_d   = 6'd0;
        end
      end
      StClear: begin
        we      = 1'b1;
        waddr   = sweep_q;
        wdata   = SPACE_CODE;
        sweep_d = sweep_q + 6'd1;
        if (sweep_q == 6'd63) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cur_q   <= 6'd0;
      sweep_q <= 6'd0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      sweep_q <= sweep_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Cells; i++) begin
        cell_q[i] <= SPACE_CODE;
      end
    end else if (we) begin
      cell_q[waddr] <= wdata;
    end
  end

  // Rows 4..15 lie outside the buffer and read as blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_code_q <= SPACE_CODE;
    end else if (bus.char_xy[7:6] != 2'b00) begin
      char_code_q <= SPACE_CODE;
    end else begin
      char_code_q <= cell_q[bus.char_xy[5:0]];
    end
  end

endmodule
